// File: rtl/i2c_shift_register_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_shift_register_param                               |
// | Description : Parametrised I2C data shift register. Serialises a     |
// |               loaded word onto SDA and deserialises SDA into a       |
// |               parallel word, one bit per SCL period. SCL edges are   |
// |               detected in the system clock domain. The optional ACK  |
// |               bit slot is enabled with the macro I2C_SHIFT_ACK_EN.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2c_shift_register_param #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ClockI2C,
  input  logic             ShiftIn,
  input  logic [WIDTH-1:0] SentData,
  input  logic             WriteLoad,
  input  logic             ShiftOrHold,
  input  logic             AckDrive,
  output logic [WIDTH-1:0] ReceivedData,
  output logic             ShiftOut,
  output logic [CNT_W-1:0] BitCount,
  output logic             Busy,
  output logic             ByteDone,
  output logic             AckReceived
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam logic [CNT_W-1:0] c_WORD_LEN = CNT_W'(WIDTH);

  logic [1:0]       r_state;
  logic             r_scl_prev;
  logic             r_sample;
  logic [WIDTH-1:0] r_data;
  logic             r_shout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_ack;

  logic             w_rise;
  logic             w_fall;
  logic             w_shift_ev;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_out;
  logic             w_load_bit;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_rise     = ClockI2C & ~r_scl_prev;
  assign w_fall     = ~ClockI2C & r_scl_prev;
  assign w_shift_ev = w_fall & ShiftOrHold;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  // Bit order selects which end the sampled bit enters and which end drives SDA.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted  = {r_data[WIDTH-2:0], r_sample};
      assign w_next_out = w_shifted[WIDTH-1];
      assign w_load_bit = SentData[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted  = {r_sample, r_data[WIDTH-1:1]};
      assign w_next_out = w_shifted[0];
      assign w_load_bit = SentData[0];
    end
  endgenerate

`ifndef I2C_SHIFT_ACK_EN
  // Without the ACK slot the driven ACK level has no destination.
  logic w_unused_ack;
  assign w_unused_ack = AckDrive;
`endif

  // Edge detection, SDA sampling, load/shift datapath and word-sequencing FSM.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_scl_prev <= 1'b0;
      r_sample   <= 1'b0;
      r_data     <= '0;
      r_shout    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_scl_prev <= ClockI2C;
      r_done     <= 1'b0;
      if (w_rise) begin
        r_sample <= ShiftIn;
      end
      // A load wins over any coincident SCL fall and aborts a word in flight.
      if (WriteLoad) begin
        r_data  <= SentData;
        r_shout <= w_load_bit;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_state <= ST_SHIFT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Receive-only start: first fall begins a word with no prior load.
            if (w_shift_ev) begin
              r_data  <= w_shifted;
              r_shout <= w_next_out;
              r_cnt   <= CNT_W'(1);
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (w_shift_ev) begin
              r_data  <= w_shifted;
              r_shout <= w_next_out;
              r_cnt   <= w_cnt_inc;
              if (w_cnt_inc == c_WORD_LEN) begin
`ifdef I2C_SHIFT_ACK_EN
                r_state <= ST_ACK;
                r_shout <= AckDrive;
`else
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
`endif
              end
            end
          end
`ifdef I2C_SHIFT_ACK_EN
          ST_ACK: begin
            if (w_rise) begin
              r_ack <= ShiftIn;
            end
            // Closing fall of the ACK slot ends the word and releases SDA.
            if (w_shift_ev) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_shout <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
`endif
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ReceivedData = r_data;
  assign ShiftOut     = r_shout;
  assign BitCount     = r_cnt;
  assign Busy         = r_busy;
  assign ByteDone     = r_done;
  assign AckReceived  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_shift_register_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_i2c_shift_register_param                            |
// | Description : Self-checking bench for i2c_shift_register_param.      |
// |               Completed words are checked by a ByteDone-driven       |
// |               scoreboard; ACK expectations follow I2C_SHIFT_ACK_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_i2c_shift_register_param;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ClockI2C;
  logic       ShiftIn;
  logic [7:0] SentData;
  logic       WriteLoad;
  logic       ShiftOrHold;
  logic       AckDrive;

  logic [7:0] ReceivedData;
  logic       ShiftOut;
  logic [5:0] BitCount;
  logic       Busy;
  logic       ByteDone;
  logic       AckReceived;

  logic [7:0] l_ReceivedData;
  logic       l_ShiftOut;
  logic [5:0] l_BitCount;
  logic       l_Busy;
  logic       l_ByteDone;
  logic       l_AckReceived;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic [5:0] cnt;
    logic       ack;
  } word_t;

  word_t sb[$];

  always #5 Clock = ~Clock;

  i2c_shift_register_param #(.WIDTH(8), .MSB_FIRST(1), .CNT_W(6)) u_dut (
    .Clock(Clock), .Reset(Reset), .ClockI2C(ClockI2C), .ShiftIn(ShiftIn),
    .SentData(SentData), .WriteLoad(WriteLoad), .ShiftOrHold(ShiftOrHold),
    .AckDrive(AckDrive), .ReceivedData(ReceivedData), .ShiftOut(ShiftOut),
    .BitCount(BitCount), .Busy(Busy), .ByteDone(ByteDone), .AckReceived(AckReceived)
  );

  i2c_shift_register_param #(.WIDTH(8), .MSB_FIRST(0), .CNT_W(6)) u_dut_lsb (
    .Clock(Clock), .Reset(Reset), .ClockI2C(ClockI2C), .ShiftIn(ShiftIn),
    .SentData(SentData), .WriteLoad(WriteLoad), .ShiftOrHold(ShiftOrHold),
    .AckDrive(AckDrive), .ReceivedData(l_ReceivedData), .ShiftOut(l_ShiftOut),
    .BitCount(l_BitCount), .Busy(l_Busy), .ByteDone(l_ByteDone), .AckReceived(l_AckReceived)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    SentData  = w;
    WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
  endtask

  // One SCL period: two cycles high, two low. Returns just after the fall response.
  task automatic scl_rise_fall(input logic sda);
    ShiftIn  = sda;
    ClockI2C = 1'b1;
    tick();
    tick();
    ClockI2C = 1'b0;
    tick();
  endtask

  task automatic period(input logic sda);
    scl_rise_fall(sda);
    tick();
  endtask

  task automatic expect_word(input logic [7:0] data, input logic ack_sda);
    word_t e;
    e.data = data;
    e.cnt  = 6'd8;
`ifdef I2C_SHIFT_ACK_EN
    e.ack  = ack_sda;
`else
    e.ack  = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Closes a word after its 8th shift: ACK slot when enabled, otherwise idle checks.
  task automatic finish_word(input logic ack_sda);
`ifdef I2C_SHIFT_ACK_EN
    chk("ack_slot_sdo", {31'd0, ShiftOut}, 32'd0);
    chk("ack_slot_busy", {31'd0, Busy}, 32'd1);
    scl_rise_fall(ack_sda);
    chk("ack_sda_release", {31'd0, ShiftOut}, 32'd1);
    chk("ack_end_busy", {31'd0, Busy}, 32'd0);
    tick();
`else
    chk("word_end_busy", {31'd0, Busy}, 32'd0);
    chk("word_end_ackrx", {31'd0, AckReceived}, {31'd0, ack_sda & 1'b0});
    tick();
`endif
  endtask

  // Scoreboard monitor: every ByteDone pulse must match the oldest expected word.
  always @(negedge Clock) begin
    if (ByteDone) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL bytedone_unexpected: got pulse with data 0x%0h count %0d, expected none at %0t",
                 ReceivedData, BitCount, $time);
      end else begin
        word_t e;
        e = sb.pop_front();
        chk("word_data", {24'd0, ReceivedData}, {24'd0, e.data});
        chk("word_count", {26'd0, BitCount}, {26'd0, e.cnt});
        chk("word_ackrx", {31'd0, AckReceived}, {31'd0, e.ack});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    Reset = 1'b0; ClockI2C = 1'b0; ShiftIn = 1'b0; SentData = 8'h00;
    WriteLoad = 1'b0; ShiftOrHold = 1'b1; AckDrive = 1'b0;

    // Reset held while every input toggles.
    for (int i = 0; i < 3; i++) begin
      ClockI2C = i[0]; ShiftIn = ~i[0]; WriteLoad = 1'b1;
      SentData = 8'hFF; AckDrive = i[0];
      tick();
      chk("rst_data",   {24'd0, ReceivedData}, 32'd0);
      chk("rst_sdo",    {31'd0, ShiftOut},     32'd0);
      chk("rst_count",  {26'd0, BitCount},     32'd0);
      chk("rst_busy",   {31'd0, Busy},         32'd0);
      chk("rst_done",   {31'd0, ByteDone},     32'd0);
      chk("rst_ackrx",  {31'd0, AckReceived},  32'd0);
    end
    ClockI2C = 1'b0; WriteLoad = 1'b0; AckDrive = 1'b0; ShiftIn = 1'b0;
    Reset = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);

    // Load 0xA5, receive 0x3C MSB first.
    load(8'hA5);
    chk("ld_a5_sdo", {31'd0, ShiftOut}, 32'd1);
    chk("ld_a5_count", {26'd0, BitCount}, 32'd0);
    chk("ld_a5_busy", {31'd0, Busy}, 32'd1);
    expect_word(8'h3C, 1'b0);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a5;
      a5 = 8'hA5;
      period(pat[7-i]);
      if (i < 7) chk("tx_a5_sdo", {31'd0, ShiftOut}, {31'd0, a5[6-i]});
    end
    finish_word(1'b0);

    // Load 0x01, SDA held low; LSB-first instance shifts out 1 then zeros.
    load(8'h01);
    chk("lsb_first_sdo", {31'd0, l_ShiftOut}, 32'd1);
    expect_word(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      period(1'b0);
      chk("lsb_tx_sdo", {31'd0, l_ShiftOut}, 32'd0);
    end
    chk("lsb_rx_data", {24'd0, l_ReceivedData}, 32'd0);
    chk("lsb_rx_count", {26'd0, l_BitCount}, 32'd8);
    finish_word(1'b1);

    // Hold: 3 shifts, 4 held periods, 5 more shifts.
    load(8'hF0);
    expect_word(8'hB3, 1'b0);
    period(1'b1); period(1'b0); period(1'b1);
    chk("pre_hold_data", {24'd0, ReceivedData}, 32'h85);
    ShiftOrHold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      period(1'b0);
      chk("hold_count", {26'd0, BitCount}, 32'd3);
      chk("hold_data", {24'd0, ReceivedData}, 32'h85);
      chk("hold_sdo", {31'd0, ShiftOut}, 32'd1);
    end
    ShiftOrHold = 1'b1;
    period(1'b1); period(1'b0); period(1'b0); period(1'b1); period(1'b1);
    finish_word(1'b0);

    // Load coincident with a fall: the fall is discarded.
    ShiftIn = 1'b1; ClockI2C = 1'b1;
    tick(); tick();
    ClockI2C = 1'b0; SentData = 8'h55; WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
    chk("ld_fall_count", {26'd0, BitCount}, 32'd0);
    chk("ld_fall_data", {24'd0, ReceivedData}, 32'h55);
    chk("ld_fall_sdo", {31'd0, ShiftOut}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) period(1'b1);
    chk("four_shift_count", {26'd0, BitCount}, 32'd4);
    chk("four_shift_data", {24'd0, ReceivedData}, 32'h5F);
    // Mid-word reload aborts silently.
    load(8'h0F);
    chk("reload_count", {26'd0, BitCount}, 32'd0);
    chk("reload_data", {24'd0, ReceivedData}, 32'h0F);
    for (int i = 0; i < 5; i++) period(1'b0);
    chk("five_shift_data", {24'd0, ReceivedData}, 32'hE0);
    // Reset mid-word clears everything without a ByteDone.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("midrst_data", {24'd0, ReceivedData}, 32'd0);
    chk("midrst_count", {26'd0, BitCount}, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("midrst_idle_busy", {31'd0, Busy}, 32'd0);

    // Receive-only start from IDLE, no load.
    expect_word(8'hCA, 1'b1);
    pat = 8'hCA;
    period(pat[7]);
    chk("idle_start_count", {26'd0, BitCount}, 32'd1);
    chk("idle_start_busy", {31'd0, Busy}, 32'd1);
    for (int i = 1; i < 8; i++) period(pat[7-i]);
    finish_word(1'b1);

    tick(); tick(); tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
